keypad_scanner: RTL and testbench

Front-end stage that drives the 4x4 numpad matrix and its alternate-keyboard button, debounces them, and hands the calculator core one 6-bit key code per physical press. It sits directly upstream of the key-decode/stack-control logic. That logic acts on every cycle the code is valid, so this block must present each press as exactly one valid cycle.

---
 rtl/keypad_scanner.sv | 225 ++++++++++++++++++++++
 tb/tb_keypad_scanner.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : keypad_scanner
// Purpose  : Scans a 4x4 active-low key matrix plus an alternate-keyboard
//            button, debounces both over whole sweeps, and emits one
//            registered 6-bit key code per accepted press.
// Ports    : clock_i      - system clock
//            reset_i      - synchronous active-high reset
//            alt_key_i    - alternate-keyboard button (async, active-high)
//            rows_i[3:0]  - row sense, active-low
//            columns_o    - column drive, one-hot-low
//            alt_led_o    - alt mode armed
//            value_o[5:0] - {valid, ~alt, col[1:0], row[1:0]}, 1-cycle pulse
// Revision : 1.0 - initial release
// ============================================================================
module keypad_scanner #(
  parameter int SCAN_DIV        = 5000,
  parameter int DEBOUNCE_SWEEPS = 25
) (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       alt_key_i,
  input  logic [3:0] rows_i,
  output logic [3:0] columns_o,
  output logic       alt_led_o,
  output logic [5:0] value_o
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DEB_W = $clog2(DEBOUNCE_SWEEPS + 1);
  localparam logic [DIV_W-1:0] C_DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DEB_W-1:0] C_DEB_MAX  = DEB_W'(DEBOUNCE_SWEEPS);
  localparam logic [DEB_W-1:0] C_DEB_ONE  = DEB_W'(1);
  localparam bit               C_ONE_SWEEP = (DEBOUNCE_SWEEPS == 1);

  typedef enum logic [1:0] {
    S_RELEASED     = 2'd0,
    S_PRESS_WAIT   = 2'd1,
    S_HELD         = 2'd2,
    S_RELEASE_WAIT = 2'd3
  } state_t;

  state_t           state_q;
  logic [3:0]       rows_s1_q, rows_s2_q;
  logic             alt_s1_q, alt_s2_q;
  logic [DIV_W-1:0] div_q;
  logic [1:0]       col_q;
  logic [1:0]       acc_n_q;          // hits so far this sweep: 0, 1, 2 = many
  logic [1:0]       acc_c_q, acc_r_q;
  logic [1:0]       cand_c_q, cand_r_q;
  logic [DEB_W-1:0] stable_q;
  logic             alt_db_q;
  logic [DEB_W-1:0] alt_cnt_q;
  logic             alt_mode_q;
  logic [5:0]       value_q;

  logic             slot_end_d, sweep_end_d;
  logic [3:0]       col_hits_d;
  logic [2:0]       col_pop_d, sum_d;
  logic [1:0]       col_row_d, col_n_d, total_n_d;
  logic [1:0]       key_c_d, key_r_d;
  logic             res_none_d, res_key_d, same_key_d;
  logic [DEB_W-1:0] stable_inc_d, alt_cnt_inc_d;
  logic             alt_differs_d, alt_accept_d, alt_toggle_d;
  logic [5:0]       code_d;

  always_comb begin
    slot_end_d  = (div_q == C_DIV_LAST);
    sweep_end_d = slot_end_d && (col_q == 2'd3);

    // Hits in the column being sampled now; the row index is only
    // meaningful when exactly one row is low.
    col_hits_d = ~rows_s2_q;
    col_pop_d  = 3'd0;
    col_row_d  = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (col_hits_d[i]) begin
        col_pop_d = col_pop_d + 3'd1;
        col_row_d = 2'(i);
      end
    end
    col_n_d   = (col_pop_d >= 3'd2) ? 2'd2 : col_pop_d[1:0];
    sum_d     = {1'b0, acc_n_q} + {1'b0, col_n_d};
    total_n_d = (sum_d >= 3'd2) ? 2'd2 : sum_d[1:0];

    if (col_n_d == 2'd1) begin
      key_c_d = col_q;
      key_r_d = col_row_d;
    end else begin
      key_c_d = acc_c_q;
      key_r_d = acc_r_q;
    end

    res_none_d = (total_n_d == 2'd0);
    res_key_d  = (total_n_d == 2'd1);
    same_key_d = res_key_d && (key_c_d == cand_c_q) && (key_r_d == cand_r_q);

    stable_inc_d  = (stable_q  == C_DEB_MAX) ? stable_q  : stable_q  + C_DEB_ONE;
    alt_cnt_inc_d = (alt_cnt_q == C_DEB_MAX) ? alt_cnt_q : alt_cnt_q + C_DEB_ONE;

    alt_differs_d = (alt_s2_q != alt_db_q);
    alt_accept_d  = alt_differs_d && (alt_cnt_inc_d == C_DEB_MAX);
    alt_toggle_d  = sweep_end_d && alt_accept_d && alt_s2_q;

    // Code uses alt mode as it stands before any toggle at this sweep end.
    code_d = {1'b1, ~alt_mode_q, key_c_d, key_r_d};
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q    <= S_RELEASED;
      rows_s1_q  <= 4'd0;
      rows_s2_q  <= 4'd0;
      alt_s1_q   <= 1'b0;
      alt_s2_q   <= 1'b0;
      div_q      <= '0;
      col_q      <= 2'd0;
      acc_n_q    <= 2'd0;
      acc_c_q    <= 2'd0;
      acc_r_q    <= 2'd0;
      cand_c_q   <= 2'd0;
      cand_r_q   <= 2'd0;
      stable_q   <= '0;
      alt_db_q   <= 1'b0;
      alt_cnt_q  <= '0;
      alt_mode_q <= 1'b0;
      value_q    <= 6'd0;
    end else begin
      rows_s1_q <= rows_i;
      rows_s2_q <= rows_s1_q;
      alt_s1_q  <= alt_key_i;
      alt_s2_q  <= alt_s1_q;
      value_q   <= 6'd0;

      if (slot_end_d) begin
        div_q <= '0;
        col_q <= col_q + 2'd1;
        if (sweep_end_d) begin
          acc_n_q <= 2'd0;
        end else begin
          acc_n_q <= total_n_d;
          if (col_n_d == 2'd1) begin
            acc_c_q <= col_q;
            acc_r_q <= col_row_d;
          end
        end
      end else begin
        div_q <= div_q + DIV_W'(1);
      end

      // A toggle beats the one-shot clear that follows an alt-mode code.
      if (alt_toggle_d) begin
        alt_mode_q <= ~alt_mode_q;
      end else if (value_q[5] && !value_q[4]) begin
        alt_mode_q <= 1'b0;
      end

      if (sweep_end_d) begin
        if (!alt_differs_d) begin
          alt_cnt_q <= '0;
        end else if (alt_accept_d) begin
          alt_db_q  <= alt_s2_q;
          alt_cnt_q <= '0;
        end else begin
          alt_cnt_q <= alt_cnt_inc_d;
        end

        case (state_q)
          S_RELEASED: begin
            if (res_key_d) begin
              cand_c_q <= key_c_d;
              cand_r_q <= key_r_d;
              stable_q <= C_DEB_ONE;
              if (C_ONE_SWEEP) begin
                value_q <= code_d;
                state_q <= S_HELD;
              end else begin
                state_q <= S_PRESS_WAIT;
              end
            end
          end
          S_PRESS_WAIT: begin
            if (same_key_d) begin
              stable_q <= stable_inc_d;
              if (stable_inc_d == C_DEB_MAX) begin
                value_q <= code_d;
                state_q <= S_HELD;
              end
            end else if (res_key_d) begin
              cand_c_q <= key_c_d;
              cand_r_q <= key_r_d;
              stable_q <= C_DEB_ONE;
            end else begin
              state_q <= S_RELEASED;
            end
          end
          S_HELD: begin
            if (res_none_d) begin
              stable_q <= C_DEB_ONE;
              state_q  <= C_ONE_SWEEP ? S_RELEASED : S_RELEASE_WAIT;
            end
          end
          S_RELEASE_WAIT: begin
            if (res_none_d) begin
              stable_q <= stable_inc_d;
              if (stable_inc_d == C_DEB_MAX) begin
                state_q <= S_RELEASED;
              end
            end else begin
              state_q <= S_HELD;
            end
          end
          default: state_q <= S_RELEASED;
        endcase
      end
    end
  end

  assign columns_o = ~(4'b0001 << col_q);
  assign alt_led_o = alt_mode_q;
  assign value_o   = value_q;

endmodule
`default_nettype wire

// File: tb/tb_keypad_scanner.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_keypad_scanner
// Purpose  : Directed bench for keypad_scanner with SCAN_DIV=4,
//            DEBOUNCE_SWEEPS=3 (one sweep = 16 clocks). A behavioural key
//            matrix drives rows from columns; every nonzero value is logged
//            with its cycle number and compared against hand-derived codes
//            and emission cycles.
// Revision : 1.0 - initial release
// ============================================================================
module tb_keypad_scanner;

  localparam int SW = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       alt_key = 1'b0;
  logic [3:0] rows;
  logic [3:0] columns;
  logic       alt_led;
  logic [5:0] value;
  logic [15:0] keys = 16'd0;   // bit c*4+r = key (c,r) pressed

  int cyc  = 0;
  int vecs = 0;
  int errs = 0;

  typedef struct {
    int         cyc;
    logic [5:0] code;
  } emit_t;
  emit_t emits[$];

  typedef struct {
    int         c;
    int         r;
    logic [5:0] exp_code;
  } vec_t;
  vec_t tbl[4];

  keypad_scanner #(
    .SCAN_DIV        (4),
    .DEBOUNCE_SWEEPS (3)
  ) dut (
    .clock_i   (clk),
    .reset_i   (rst),
    .alt_key_i (alt_key),
    .rows_i    (rows),
    .columns_o (columns),
    .alt_led_o (alt_led),
    .value_o   (value)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    rows = 4'hF;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (keys[c*4+r] && !columns[c]) rows[r] = 1'b0;
  end

  always @(negedge clk) begin
    if (value !== 6'd0) emits.push_back('{cyc, value});
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_until(input int k);
    if (cyc < k) tick(k - cyc);
  endtask

  task automatic do_reset(output int t0);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    t0 = cyc;
  endtask

  task automatic chk_single(input string name, input logic [5:0] code, input int at);
    chk({name, " count"}, emits.size(), 1);
    if (emits.size() > 0) begin
      chk({name, " code"}, emits[0].code, code);
      chk({name, " cycle"}, emits[0].cyc, at);
    end
  endtask

  initial begin
    int t0;
    int t1;
    logic [3:0] ec;

    tbl[0] = '{2, 1, 6'b111001};
    tbl[1] = '{0, 0, 6'b110000};
    tbl[2] = '{3, 3, 6'b111111};
    tbl[3] = '{1, 2, 6'b110110};

    // Reset state and idle scanning.
    do_reset(t0);
    emits.delete();
    chk("reset columns", columns, 4'b1110);
    chk("reset value", value, 6'd0);
    chk("reset alt_led", alt_led, 1'b0);
    for (int i = 0; i < 200; i++) begin
      tick(1);
      ec = ~(4'b0001 << (((cyc - t0) / 4) % 4));
      chk("idle columns", columns, ec);
      chk("idle alt_led", alt_led, 1'b0);
    end
    chk("idle no codes", emits.size(), 0);

    // Single clean presses held 10 sweeps: one code after the 3rd sweep.
    for (int v = 0; v < 4; v++) begin
      do_reset(t0);
      emits.delete();
      keys = 16'd1 << (tbl[v].c * 4 + tbl[v].r);
      tick(10 * SW);
      keys = 16'd0;
      tick(5 * SW);
      chk_single($sformatf("key(%0d,%0d)", tbl[v].c, tbl[v].r), tbl[v].exp_code, t0 + 3 * SW);
    end

    // Chatter on (0,0) from t0+12 toggling every 7 cycles until t0+44.
    do_reset(t0);
    emits.delete();
    wait_until(t0 + 12);
    keys = 16'h0001;
    for (int k = 19; k <= 40; k += 7) begin
      wait_until(t0 + k);
      keys = keys ^ 16'h0001;
    end
    wait_until(t0 + 44);
    keys = 16'h0001;
    wait_until(t0 + 6 * SW + 2 * SW);
    keys = 16'd0;
    tick(5 * SW);
    chk_single("chatter", 6'b110000, t0 + 6 * SW);

    // Alt button for 5 sweeps, then (1,0) in alt mode.
    do_reset(t0);
    emits.delete();
    alt_key = 1'b1;
    wait_until(t0 + 47);
    chk("alt_led before debounce", alt_led, 1'b0);
    tick(1);
    chk("alt_led after debounce", alt_led, 1'b1);
    wait_until(t0 + 80);
    alt_key = 1'b0;
    wait_until(t0 + 128);
    chk("alt_led after button release", alt_led, 1'b1);
    keys = 16'h0001 << 4;
    wait_until(t0 + 176);
    chk("alt_led during alt code", alt_led, 1'b1);
    tick(1);
    chk("alt_led one-shot clear", alt_led, 1'b0);
    wait_until(t0 + 176 + 5 * SW);
    keys = 16'd0;
    tick(5 * SW);
    chk_single("alt key(1,0)", 6'b100100, t0 + 176);
    chk("alt_led stays clear", alt_led, 1'b0);

    // Two keys together give nothing; dropping (3,3) lets (0,0) through.
    do_reset(t0);
    emits.delete();
    keys = 16'h8001;
    wait_until(t0 + 80);
    chk("multi no code", emits.size(), 0);
    keys = 16'h0001;
    wait_until(t0 + 160);
    keys = 16'd0;
    tick(5 * SW);
    chk_single("multi then (0,0)", 6'b110000, t0 + 128);

    // Reset during the second debounce sweep of (1,1) discards progress.
    do_reset(t0);
    emits.delete();
    keys = 16'h0001 << 5;
    wait_until(t0 + 24);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    t1 = cyc;
    wait_until(t1 + 3 * SW + 2 * SW);
    keys = 16'd0;
    tick(5 * SW);
    chk_single("reset mid-debounce", 6'b110101, t1 + 3 * SW);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
`default_nettype wire
